// File: rtl/hf1_pkg.sv
// Shared types and constants for the HF1 seven-segment scanner.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}; dp is kept off everywhere.
package hf1_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Digit index: which of the four digits is currently driven.
  typedef enum logic [1:0] {
    DIG_STD  = 2'd0,
    DIG_MAN  = 2'd1,
    DIG_IND  = 2'd2,
    DIG_STAT = 2'd3
  } dig_idx_t;

  // Active-low anode patterns, one low bit per digit.
  localparam logic [3:0] AN_STD  = 4'b1110;
  localparam logic [3:0] AN_MAN  = 4'b1101;
  localparam logic [3:0] AN_IND  = 4'b1011;
  localparam logic [3:0] AN_STAT = 4'b0111;

  // Frame snapshot of the three implementation outputs.
  typedef struct packed {
    logic [2:0] std_v;
    logic [2:0] man_v;
    logic [2:0] ind_v;
  } snap_t;

  function automatic logic [3:0] an_pattern(input dig_idx_t idx);
    case (idx)
      DIG_STD:  an_pattern = AN_STD;
      DIG_MAN:  an_pattern = AN_MAN;
      DIG_IND:  an_pattern = AN_IND;
      default:  an_pattern = AN_STAT;
    endcase
  endfunction

  function automatic dig_idx_t dig_next(input dig_idx_t idx);
    case (idx)
      DIG_STD:  dig_next = DIG_MAN;
      DIG_MAN:  dig_next = DIG_IND;
      DIG_IND:  dig_next = DIG_STAT;
      default:  dig_next = DIG_STD;
    endcase
  endfunction

endpackage

// File: rtl/hf1_seg_dec.sv
// 3-bit value to active-low seven-segment code (dp off). Purely combinational.
module hf1_seg_dec
  import hf1_pkg::*;
(
  input  logic [2:0] i_val,
  output logic [7:0] o_seg
);

  // Value lookup
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_val)
      3'd0: o_seg = SEG_0;
      3'd1: o_seg = SEG_1;
      3'd2: o_seg = SEG_2;
      3'd3: o_seg = SEG_3;
      3'd4: o_seg = SEG_4;
      3'd5: o_seg = SEG_5;
      3'd6: o_seg = SEG_6;
      3'd7: o_seg = SEG_7;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hf1_seg_scan.sv
// Four-digit multiplexed display of the three HF1 implementation outputs
// plus a status digit. Inputs are snapshotted once per frame.
// Optional consistency checker: define HF1_SEG_SCAN_CHECK_EN.
module hf1_seg_scan
  import hf1_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] std_out,
  input  logic [2:0] man_out,
  input  logic [2:0] ind_out,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       err
);

  localparam logic [15:0] PRE_MAX = 16'(SCAN_DIV - 1);

  logic [15:0] r_pre;
  dig_idx_t    r_idx;
  dig_idx_t    w_idx_nxt;
  snap_t       r_snap;
  snap_t       w_snap_nxt;
  logic        w_tick;
  logic        w_frame;
  logic [2:0]  w_val_nxt;
  logic [7:0]  w_dec_seg;
  logic [7:0]  w_seg_nxt;
  logic [3:0]  w_an_nxt;
  logic [3:0]  r_an;
  logic [7:0]  r_seg;

  assign w_tick  = (r_pre == PRE_MAX);
  assign w_frame = w_tick && (r_idx == DIG_STAT);

  // Prescaler: counts one digit dwell, wraps after the tick clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_pre <= '0;
    else if (w_tick) r_pre <= '0;
    else             r_pre <= r_pre + 16'd1;
  end

  // State register: digit index, frame snapshot and registered display outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx  <= DIG_STD;
      r_snap <= '0;
      r_an   <= AN_STD;
      r_seg  <= SEG_0;
    end else if (w_tick) begin
      r_idx  <= w_idx_nxt;
      r_snap <= w_snap_nxt;
      r_an   <= w_an_nxt;
      r_seg  <= w_seg_nxt;
    end
  end

  // Next-state: index advance
  always_comb begin
    w_idx_nxt = dig_next(r_idx);
  end

  // The display is computed from the snapshot as it will be after this edge,
  // so the frame-start digit already shows the freshly captured value.
  always_comb begin
    w_snap_nxt = r_snap;
    if (w_frame) begin
      w_snap_nxt.std_v = std_out;
      w_snap_nxt.man_v = man_out;
      w_snap_nxt.ind_v = ind_out;
    end
  end

  `ifdef HF1_SEG_SCAN_CHECK_EN
  logic w_mis;
  logic r_err;

  assign w_mis = (w_snap_nxt.std_v != w_snap_nxt.man_v) ||
                 (w_snap_nxt.man_v != w_snap_nxt.ind_v);

  // Sticky mismatch flag, sampled at each frame start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_err <= 1'b0;
    else if (w_frame) r_err <= r_err | w_mis;
  end

  assign err = r_err;
  `else
  assign err = 1'b0;
  `endif

  // Output decode: next-digit value mux feeding the single decoder
  always_comb begin
    w_an_nxt  = an_pattern(w_idx_nxt);
    w_val_nxt = '0;
    case (w_idx_nxt)
      DIG_STD: w_val_nxt = w_snap_nxt.std_v;
      DIG_MAN: w_val_nxt = w_snap_nxt.man_v;
      DIG_IND: w_val_nxt = w_snap_nxt.ind_v;
      default: w_val_nxt = '0;
    endcase
    if (w_idx_nxt == DIG_STAT) begin
      `ifdef HF1_SEG_SCAN_CHECK_EN
      w_seg_nxt = w_mis ? SEG_E : SEG_BLANK;
      `else
      w_seg_nxt = SEG_BLANK;
      `endif
    end else begin
      w_seg_nxt = w_dec_seg;
    end
  end

  hf1_seg_dec u_dec (
    .i_val (w_val_nxt),
    .o_seg (w_dec_seg)
  );

  assign an  = r_an;
  assign seg = r_seg;

endmodule
